// File: rtl/pipe_debug_ctrl.sv
// pipe_debug_ctrl: byte-command debug unit that loads instruction memory,
// runs or single-steps the pipelined datapath and dumps PC/registers/data memory.
module pipe_debug_ctrl #(
  parameter int NBITS     = 32,
  parameter int RBITS     = 5,
  parameter int BANK_SIZE = 32,
  parameter int MEM_SIZE  = 5,
  parameter int RUN_LIMIT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic                o_rx_ready,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_cpu_en,
  output logic                o_cpu_rst,
  input  logic                i_halt,
  input  logic [NBITS-1:0]    i_pc,
  output logic                o_im_we,
  output logic [MEM_SIZE-1:0] o_im_addr,
  output logic [NBITS-1:0]    o_im_data,
  output logic [RBITS-1:0]    o_rb_addr,
  input  logic [NBITS-1:0]    i_rb_data,
  output logic [MEM_SIZE-1:0] o_dm_addr,
  input  logic [NBITS-1:0]    i_dm_data,
  output logic                o_busy
);
  localparam int NB  = NBITS / 8;
  localparam int TOT = 1 + BANK_SIZE + (1 << MEM_SIZE);
  localparam int IW  = $clog2(TOT + 1);
  localparam int RW  = $clog2(RUN_LIMIT + 1);
  localparam logic [IW-1:0] LAST_ITEM = IW'(TOT - 1);
  localparam logic [IW-1:0] BANK_END  = IW'(BANK_SIZE);
  localparam logic [7:0]    LAST_BYTE = 8'(NB - 1);
  localparam logic [RW-1:0] LIMIT     = RW'(RUN_LIMIT);

  typedef enum logic [3:0] {IDLE, LD_CNT, LD_DATA, LD_WR, RUN, STEP, STAT, DUMP, ACK, ERR} state_t;

  state_t            state_q, state_d;
  logic              halted_q, halted_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [1:0]        ph_q, ph_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     cnt_q, cnt_d;
  logic [7:0]        bc_q, bc_d;
  logic [7:0]        status_q, status_d;
  logic [NBITS-1:0]  word_q, word_d;
  logic [RW-1:0]     run_q, run_d;
  logic              in_rb, in_dm;

  assign o_busy     = state_q != IDLE;
  assign o_rx_ready = state_q inside {IDLE, LD_CNT, LD_DATA};
  assign o_tx_valid = state_q inside {STAT, ACK, ERR} || (state_q == DUMP && ph_q == 2'd2);
  assign o_tx_data  = state_q == STAT ? status_q :
                      state_q == ACK  ? 8'hAA :
                      state_q == ERR  ? 8'hEE :
                      o_tx_valid      ? word_q[7:0] : 8'h00;
  assign o_cpu_rst  = cpu_rst_q;
  assign o_im_we    = state_q == LD_WR;
  assign o_im_addr  = o_im_we ? idx_q[MEM_SIZE-1:0] : '0;
  assign o_im_data  = o_im_we ? word_q : '0;
  // dump item 0 is the PC, then the register bank, then data memory
  assign in_rb      = state_q == DUMP && idx_q != '0 && idx_q <= BANK_END;
  assign in_dm      = state_q == DUMP && idx_q > BANK_END;
  assign o_rb_addr  = in_rb ? RBITS'(idx_q - IW'(1)) : '0;
  assign o_dm_addr  = in_dm ? MEM_SIZE'(idx_q - BANK_END - IW'(1)) : '0;

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    cpu_rst_d = 1'b0;
    ph_d      = ph_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    bc_d      = bc_q;
    status_d  = status_q;
    word_d    = word_q;
    run_d     = run_q;
    o_cpu_en  = 1'b0;
    case (state_q)
      IDLE: if (i_rx_valid) begin
        state_d   = i_rx_data == 8'h4C ? LD_CNT :
                    i_rx_data == 8'h52 ? RUN :
                    i_rx_data == 8'h53 ? STEP :
                    i_rx_data == 8'h44 ? STAT :
                    i_rx_data == 8'h58 ? ACK : ERR;
        cpu_rst_d = i_rx_data == 8'h58;
        halted_d  = halted_q && i_rx_data != 8'h58;
        run_d     = '0;
        ph_d      = '0;
        status_d  = 8'h00;
      end
      LD_CNT: if (i_rx_valid) begin
        state_d = (i_rx_data == 8'd0 || int'(i_rx_data) > (1 << MEM_SIZE)) ? ERR : LD_DATA;
        cnt_d   = IW'(i_rx_data);
        idx_d   = '0;
        bc_d    = '0;
      end
      LD_DATA: if (i_rx_valid) begin
        word_d  = (word_q >> 8) | (NBITS'(i_rx_data) << (NBITS - 8));
        bc_d    = bc_q == LAST_BYTE ? 8'd0 : bc_q + 8'd1;
        state_d = bc_q == LAST_BYTE ? LD_WR : LD_DATA;
      end
      LD_WR: begin
        idx_d   = idx_q + IW'(1);
        state_d = idx_q + IW'(1) == cnt_q ? ACK : LD_DATA;
      end
      RUN: begin
        if (halted_q || i_halt) begin
          halted_d = 1'b1;
          status_d = 8'h01;
          state_d  = STAT;
        end else if (run_q == LIMIT) begin
          status_d = 8'h02;
          state_d  = STAT;
        end else begin
          o_cpu_en = 1'b1;
          run_d    = run_q + RW'(1);
        end
      end
      STEP: begin
        if (ph_q == 2'd0 && halted_q) begin
          status_d = 8'h01;
          state_d  = STAT;
        end else if (ph_q == 2'd0) begin
          o_cpu_en = 1'b1;
          ph_d     = 2'd1;
        end else begin
          halted_d = i_halt;
          status_d = {7'b0, i_halt};
          ph_d     = 2'd0;
          state_d  = STAT;
        end
      end
      STAT: if (i_tx_ready) begin
        state_d = DUMP;
        idx_d   = '0;
        ph_d    = 2'd0;
        bc_d    = '0;
      end
      DUMP: begin
        // phase 0 presents the address, phase 1 captures the read, phase 2 sends
        if (ph_q == 2'd0) begin
          ph_d = 2'd1;
        end else if (ph_q == 2'd1) begin
          word_d = idx_q == '0 ? i_pc : idx_q <= BANK_END ? i_rb_data : i_dm_data;
          ph_d   = 2'd2;
          bc_d   = '0;
        end else if (i_tx_ready) begin
          word_d  = word_q >> 8;
          bc_d    = bc_q + 8'd1;
          if (bc_q == LAST_BYTE) begin
            ph_d    = 2'd0;
            idx_d   = idx_q + IW'(1);
            state_d = idx_q == LAST_ITEM ? IDLE : DUMP;
          end
        end
      end
      ACK, ERR: if (i_tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      halted_q  <= 1'b0;
      cpu_rst_q <= 1'b0;
      ph_q      <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      bc_q      <= '0;
      status_q  <= '0;
      word_q    <= '0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      cpu_rst_q <= cpu_rst_d;
      ph_q      <= ph_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      bc_q      <= bc_d;
      status_q  <= status_d;
      word_q    <= word_d;
      run_q     <= run_d;
    end
  end
endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// tb_pipe_debug_ctrl: directed command script with random data and random tx
// backpressure, checked against byte streams computed from the command rules.
module tb_pipe_debug_ctrl;
  logic        clk = 0, rst = 0;
  logic [7:0]  rx_data = 0, tx_data;
  logic        rx_valid = 0, rx_ready, tx_valid, tx_ready = 1;
  logic        cpu_en, cpu_rst, halt, im_we, busy;
  logic [31:0] pc = 0, im_data, rb_data = 0, dm_data = 0;
  logic [4:0]  im_addr, rb_addr, dm_addr;

  int checks = 0, errors = 0;
  logic [31:0] rf [32];
  logic [31:0] dm [32];
  logic [31:0] words [32];
  int en_cnt = 0, halt_at = 10;
  int en_pulses = 0, rst_pulses = 0;
  logic [7:0]  txq [$], exp_q [$];
  logic [36:0] imq [$];
  bit bp = 0;
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;

  always #5 clk = ~clk;

  pipe_debug_ctrl #(.RUN_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_cpu_en(cpu_en), .o_cpu_rst(cpu_rst), .i_halt(halt), .i_pc(pc),
    .o_im_we(im_we), .o_im_addr(im_addr), .o_im_data(im_data),
    .o_rb_addr(rb_addr), .i_rb_data(rb_data),
    .o_dm_addr(dm_addr), .i_dm_data(dm_data), .o_busy(busy)
  );

  // datapath stand-in: PC advances by 4 per enabled cycle, HALT after halt_at cycles
  assign halt = en_cnt >= halt_at;
  always @(posedge clk) begin
    rb_data <= rf[rb_addr];
    dm_data <= dm[dm_addr];
    if (cpu_rst) begin
      en_cnt <= 0;
      pc     <= 0;
    end else if (cpu_en) begin
      en_cnt <= en_cnt + 1;
      pc     <= pc + 32'd4;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (im_we) imq.push_back({im_addr, im_data});
    if (cpu_en) en_pulses <= en_pulses + 1;
    if (cpu_rst) rst_pulses <= rst_pulses + 1;
    if (rst && prev_stall) begin
      chk("tx_hold_valid", 64'(tx_valid), 1);
      chk("tx_hold_data", 64'(tx_data), 64'(prev_data));
    end
    prev_stall <= rst && tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  initial forever begin
    @(posedge clk); #1;
    tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk); #1;
    rx_data = b;
    rx_valid = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rx_ready) break;
    end
    if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 1);
    @(posedge clk); #1;
    rx_valid = 0;
    rx_data = 8'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, 64'(busy), 0);
  endtask

  // expected reply: status byte, then PC, registers and data memory, 4 bytes LSB first each
  task automatic build_exp(input logic [7:0] st, input int steps);
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(st);
    for (int k = 0; k < 65; k++) begin
      w = k == 0 ? 32'(steps * 4) : k <= 32 ? rf[k-1] : dm[k-33];
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic check_resp(input string tag);
    int nbad = 0;
    chk({tag, "_len"}, 64'(txq.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i >= txq.size() || txq[i] !== exp_q[i]) nbad++;
    chk({tag, "_bytes"}, 64'(nbad), 0);
    txq.delete();
  endtask

  task automatic single(input logic [7:0] c, input logic [7:0] reply, input string tag);
    send(c);
    wait_idle({tag, "_idle"});
    exp_q.delete();
    exp_q.push_back(reply);
    check_resp(tag);
  endtask

  task automatic dump_cmd(input logic [7:0] c, input logic [7:0] st, input int steps,
                          input int en_exp, input string tag);
    int e0 = en_pulses;
    send(c);
    wait_idle({tag, "_idle"});
    chk({tag, "_en"}, 64'(en_pulses - e0), 64'(en_exp));
    build_exp(st, steps);
    check_resp(tag);
  endtask

  initial begin
    int nbad, n;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom;
      dm[i] = $urandom;
    end
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 64'(rx_ready), 1);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_tx_valid", 64'(tx_valid), 0);
    chk("rst_cpu_en", 64'(cpu_en), 0);
    chk("rst_im_we", 64'(im_we), 0);
    chk("rst_cpu_rst", 64'(cpu_rst), 0);
    @(posedge clk); #1 rst = 1;

    send(8'h4C); send(8'h02);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    send(8'h88); send(8'h77); send(8'h66); send(8'h55);
    wait_idle("load_idle");
    exp_q.delete(); exp_q.push_back(8'hAA);
    check_resp("load_ack");
    chk("load_we_cycles", 64'(imq.size()), 2);
    if (imq.size() == 2) begin
      chk("load_w0", 64'(imq[0]), {27'd0, 5'd0, 32'h11223344});
      chk("load_w1", 64'(imq[1]), {27'd0, 5'd1, 32'h55667788});
    end
    chk("load_no_en", 64'(en_pulses), 0);

    imq.delete();
    send(8'h4C); send(8'h20);
    for (int w = 0; w < 32; w++) begin
      words[w] = $urandom;
      for (int b = 0; b < 4; b++) send(words[w][8*b +: 8]);
    end
    wait_idle("load32_idle");
    exp_q.delete(); exp_q.push_back(8'hAA);
    check_resp("load32_ack");
    chk("load32_we_cycles", 64'(imq.size()), 32);
    nbad = 0;
    foreach (imq[i]) if (i >= 32 || imq[i] !== {5'(i), words[i]}) nbad++;
    chk("load32_words", 64'(nbad), 0);

    send(8'h4C); single(8'h00, 8'hEE, "load_zero");
    send(8'h4C); single(8'h21, 8'hEE, "load_too_big");
    single(8'h7A, 8'hEE, "bad_cmd");

    dump_cmd(8'h52, 8'h01, 10, 10, "run_halt");
    dump_cmd(8'h52, 8'h01, 10, 0, "run_halted");

    halt_at = 1000;
    n = rst_pulses;
    single(8'h58, 8'hAA, "reset_cmd");
    chk("cpu_rst_pulses", 64'(rst_pulses - n), 1);

    bp = 1;
    for (int s = 1; s <= 3; s++) dump_cmd(8'h53, 8'h00, s, 1, $sformatf("step%0d", s));
    dump_cmd(8'h52, 8'h02, 19, 16, "run_limit");
    halt_at = 20;
    dump_cmd(8'h53, 8'h01, 20, 1, "step_to_halt");
    dump_cmd(8'h53, 8'h01, 20, 0, "step_halted");
    dump_cmd(8'h44, 8'h00, 20, 0, "dump_bp");
    bp = 0;

    imq.delete();
    send(8'h4C); send(8'h01);
    repeat (20) @(negedge clk);
    chk("stuck_load_busy", 64'(busy), 1);
    chk("stuck_load_no_we", 64'(imq.size()), 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1 rst = 1;
    txq.delete();

    send(8'h44);
    for (int i = 0; i < 2000 && txq.size() < 40; i++) @(negedge clk);
    @(posedge clk); #1 rst = 0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_tx_valid", 64'(tx_valid), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_rx_ready", 64'(rx_ready), 1);
    end
    @(posedge clk); #1 rst = 1;
    n = txq.size();
    repeat (20) @(negedge clk);
    chk("mid_rst_no_tx", 64'(txq.size()), 64'(n));
    chk("mid_rst_partial", 64'(n < 262), 1);
    txq.delete();
    dump_cmd(8'h44, 8'h00, 20, 0, "dump_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
